hilo_mdu: RTL and testbench
===========================

Name: hilo_mdu

Overview:
- Multi-cycle multiply/divide unit that produces the write side of the HI/LO register pair.
- Executes MULT, MULTU, DIV and DIVU on two 32-bit operands using iterative shift-add and restoring division.
- Drives registered results (hi_out/lo_out) and one-cycle write enables (hi_we/lo_we) straight into the HI/LO register write port.
- busy lets the pipeline stall dependent MFHI/MFLO and further mult/div instructions.

Parameters:
- WIDTH, 32, operand width; HI/LO width; iteration count.
- CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  launch operation; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- rs_data  in  WIDTH  multiplicand / dividend.
- rt_data  in  WIDTH  multiplier / divisor.
- cancel  in  1  abort in-flight operation (exception flush).
- busy  out  1  high while an operation is in flight.
- hi_out  out  WIDTH  HI result (product[63:32] or remainder).
- lo_out  out  WIDTH  LO result (product[31:0] or quotient).
- hi_we  out  1  one-cycle HI write enable.
- lo_we  out  1  one-cycle LO write enable.

Behaviour:
- Reset (rst=0, async): state=IDLE, busy=0, hi_we=lo_we=0, hi_out=lo_out=0, counter and operand registers cleared.
- States: IDLE -> CALC -> SIGN -> IDLE.
- IDLE, edge E0 with start=1 and cancel=0:
  - latch op;
  - for signed ops latch |rs|, |rt| and sign flags; for unsigned ops latch raw values;
  - cnt=0; go to CALC.
- CALC: one iteration per edge, E1..E32.
  - Multiply: 64-bit shift-add, one multiplier bit per edge.
  - Divide: restoring step; shift {rem,quot} left 1; subtract divisor if rem >= divisor and set quotient bit.
  - After cnt reaches WIDTH-1, go to SIGN.
- SIGN, edge E33: load hi_out/lo_out, assert hi_we=lo_we=1 for exactly one cycle, return to IDLE.
- Sign fix-up:
  - MULT: negate the 64-bit product if operand signs differ.
  - DIV: negate the quotient if signs differ; the remainder takes the dividend's sign.
- busy=1 from after E0 through E33; it falls in the same cycle hi_we/lo_we are high.
- Total latency: write enables high in the cycle after E33; HI/LO update at E34.
- Back-to-back: a start in the cycle hi_we is high is accepted (state is IDLE).
- start while busy: ignored, with no effect on the current op.
- Operands must be held only at E0; later changes are ignored.
- Divide by zero (rt=0), signed or unsigned:
  - full 32-cycle latency;
  - LO=0xFFFFFFFF, HI=raw rs_data;
  - no sign fix-up.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0x00000000, with no special casing beyond two's-complement wrap.
- Multiply never overflows; the full 64-bit product is returned.
- Width rules: abs/negate operate modulo 2^32 (|0x80000000| = 0x80000000 unsigned); the product is 64 bits wide.
- cancel (any state except IDLE):
  - next edge returns to IDLE with busy=0;
  - no we pulse; hi_out/lo_out keep their old values.
- cancel and start together in IDLE: the start is dropped.
- rst low mid-operation: immediate return to the reset values above; no write is issued.
- hi_we and lo_we always pulse together; they are separate ports so the HI/LO write port can also be driven independently by MTHI/MTLO logic outside this block.

Decomposition:
- Shared package (mdu_pkg):
  - op encodings MDU_MULT/MULTU/DIV/DIVU;
  - state enum IDLE/CALC/SIGN;
  - WIDTH constant;
  - DIV0_LO constant 0xFFFFFFFF.
- One natural sub-module, hilo_mdu_step:
  - combinational single iteration (add-shift or restore-subtract) selected by an is_div input;
  - the top keeps the FSM, counter, operand/result registers and sign fix-up.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; hi_we=lo_we=1 for exactly one cycle after E33; busy low that same cycle.
- MULT 0xFFFFFFFD x 0x00000005 (-3x5) -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
- DIV 0xFFFFFFF9 / 2 (-7/2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x00001234 / 0 and DIV 0xFFFFFFF0 / 0 -> LO=0xFFFFFFFF, HI=rs_data unchanged; same 33-edge latency.
- Start DIVU 100/7; pulse start with new operands at cycle 10 -> ignored, result LO=14, HI=2; a new start in the we cycle is accepted and its busy rises next cycle.
- Start MULTU, assert cancel at cycle 10 -> busy=0 next cycle, no we pulse, hi_out/lo_out unchanged; repeat with rst=0 at cycle 20 -> all outputs 0 immediately, no we after release.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package mdu_pkg;

   localparam int WIDTH = 32;
   localparam logic [WIDTH-1:0] DIV0_LO = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      SIGN = 2'b10
   } mdu_state_e;

endpackage

// File: rtl/hilo_mdu_step.sv
// One iteration of the MDU datapath: shift-add multiply or restoring divide.
module hilo_mdu_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] hi,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] opnd,
   output logic [WIDTH-1:0] hi_next,
   output logic [WIDTH-1:0] lo_next
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             ge;

   always_comb begin
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
      shifted = {hi, lo[WIDTH-1]};
      // when ge holds the difference is below the divisor, so WIDTH bits suffice
      diff    = shifted[WIDTH-1:0] - opnd;
      ge      = shifted >= {1'b0, opnd};
      if (is_div) begin
         hi_next = ge ? diff : shifted[WIDTH-1:0];
         lo_next = {lo[WIDTH-2:0], ge};
      end else begin
         hi_next = sum[WIDTH:1];
         lo_next = {sum[0], lo[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/hilo_mdu.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit driving the HI/LO register write port.
//  state | meaning
//  IDLE  | waiting for start; operands latched as magnitudes on accept
//  CALC  | one shift-add / restoring-divide iteration per cycle, WIDTH cycles
//  SIGN  | sign fix-up, load hi_out/lo_out, pulse hi_we/lo_we
module hilo_mdu #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             cancel,
   output logic             busy,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             hi_we,
   output logic             lo_we
);
   import mdu_pkg::*;

   mdu_state_e       state;
   mdu_op_e          op_q;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] opnd_b, acc_hi, acc_lo;
   logic             neg_rs, neg_rt;

   logic             in_signed, in_rs_neg, in_rt_neg;
   logic [WIDTH-1:0] rs_mag, rt_mag;
   logic             is_div, is_signed;
   logic [WIDTH-1:0] step_hi, step_lo;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0] res_hi, res_lo;

   always_comb begin
      in_signed = (op == MDU_MULT) || (op == MDU_DIV);
      in_rs_neg = in_signed & rs_data[WIDTH-1];
      in_rt_neg = in_signed & rt_data[WIDTH-1];
      rs_mag    = in_rs_neg ? -rs_data : rs_data;
      rt_mag    = in_rt_neg ? -rt_data : rt_data;
      is_div    = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
      is_signed = (op_q == MDU_MULT) || (op_q == MDU_DIV);
   end

   hilo_mdu_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (is_div),
      .hi      (acc_hi),
      .lo      (acc_lo),
      .opnd    (opnd_b),
      .hi_next (step_hi),
      .lo_next (step_lo)
   );

   // neg_rs/neg_rt are only ever set for signed ops
   always_comb begin
      prod   = {acc_hi, acc_lo};
      res_hi = acc_hi;
      res_lo = acc_lo;
      if (!is_div) begin
         if (is_signed && (neg_rs ^ neg_rt)) prod = -prod;
         res_hi = prod[2*WIDTH-1:WIDTH];
         res_lo = prod[WIDTH-1:0];
      end else begin
         // divide by zero leaves |rs| in the remainder; restoring its sign yields raw rs
         if (neg_rs) res_hi = -acc_hi;
         if (opnd_b == '0) res_lo = DIV0_LO;
         else if (neg_rs ^ neg_rt) res_lo = -acc_lo;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         op_q   <= MDU_MULT;
         cnt    <= '0;
         opnd_b <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         neg_rs <= 1'b0;
         neg_rt <= 1'b0;
         busy   <= 1'b0;
         hi_out <= '0;
         lo_out <= '0;
         hi_we  <= 1'b0;
         lo_we  <= 1'b0;
      end else begin
         hi_we <= 1'b0;
         lo_we <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !cancel) begin
                  op_q   <= mdu_op_e'(op);
                  neg_rs <= in_rs_neg;
                  neg_rt <= in_rt_neg;
                  acc_hi <= '0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= CALC;
                  if (op[1]) begin
                     acc_lo <= rs_mag;
                     opnd_b <= rt_mag;
                  end else begin
                     acc_lo <= rt_mag;
                     opnd_b <= rs_mag;
                  end
               end
            end
            CALC: begin
               if (cancel) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  acc_hi <= step_hi;
                  acc_lo <= step_lo;
                  cnt    <= cnt + 1'b1;
                  if (cnt == CNT_W'(WIDTH-1)) state <= SIGN;
               end
            end
            SIGN: begin
               busy  <= 1'b0;
               state <= IDLE;
               if (!cancel) begin
                  hi_out <= res_hi;
                  lo_out <= res_lo;
                  hi_we  <= 1'b1;
                  lo_we  <= 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_mdu.sv
// Self-checking bench for hilo_mdu: directed table, random ops vs. arithmetic model, corner sequences.
module tb_hilo_mdu;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        cancel = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] rs_data = '0;
   logic [31:0] rt_data = '0;
   logic        busy, hi_we, lo_we;
   logic [31:0] hi_out, lo_out;

   int total = 0;
   int bad = 0;
   logic [31:0] last_hi = '0;
   logic [31:0] last_lo = '0;

   always #5 clk = ~clk;

   hilo_mdu #(.WIDTH(32), .CNT_W(5)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .cancel  (cancel),
      .busy    (busy),
      .hi_out  (hi_out),
      .lo_out  (lo_out),
      .hi_we   (hi_we),
      .lo_we   (lo_we)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] hi;
      logic [31:0] lo;
      string       name;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer arithmetic; returns {hi, lo}
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa = $signed(a);
      longint sb = $signed(b);
      logic [63:0] r;
      case (o)
         2'b00:   r = 64'(sa * sb);
         2'b01:   r = {32'b0, a} * {32'b0, b};
         2'b10:   r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
         default: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      endcase
      return r;
   endfunction

   task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      op = o;
      rs_data = a;
      rt_data = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      rs_data = $urandom;
      rt_data = $urandom;
      op = 2'($urandom);
   endtask

   task automatic await_done(input string name, input logic [31:0] ehi, input logic [31:0] elo,
                             input int elapsed);
      int lat = elapsed;
      int busy_low = 0;
      while (!hi_we && lat < 60) begin
         if (!busy) busy_low++;
         tick();
         lat++;
      end
      chk($sformatf("%s latency", name), 64'(lat), 64'd33);
      chk($sformatf("%s busy_held", name), 64'(busy_low), 64'd0);
      chk($sformatf("%s busy_we_cycle", name), {63'b0, busy}, 64'd0);
      chk($sformatf("%s lo_we", name), {63'b0, lo_we}, 64'd1);
      chk($sformatf("%s hi", name), {32'b0, hi_out}, {32'b0, ehi});
      chk($sformatf("%s lo", name), {32'b0, lo_out}, {32'b0, elo});
      last_hi = ehi;
      last_lo = elo;
   endtask

   task automatic run_check(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo, input string name);
      launch(o, a, b);
      await_done(name, ehi, elo, 0);
      tick();
      chk($sformatf("%s we_once", name), {63'b0, hi_we | lo_we}, 64'd0);
   endtask

   initial begin
      int we_seen;
      logic [63:0] m;
      vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
      vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg3x5"};
      vecs[2] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minsq"};
      vecs[3] = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, "mult_7xneg1"};
      vecs[4] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7d2"};
      vecs[5] = '{2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, "divu_7d2"};
      vecs[6] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf"};
      vecs[7] = '{2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, "divu_by0"};
      vecs[8] = '{2'b10, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, "div_by0"};
      vecs[9] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7dneg2"};

      // reset values
      repeat (2) tick();
      chk("reset busy", {63'b0, busy}, 64'd0);
      chk("reset we", {62'b0, hi_we, lo_we}, 64'd0);
      chk("reset hilo", {hi_out, lo_out}, 64'd0);
      rst = 1'b1;
      tick();

      foreach (vecs[i])
         run_check(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo, vecs[i].name);

      for (int i = 0; i < 30; i++) begin
         logic [1:0]  ro = 2'($urandom);
         logic [31:0] ra = $urandom;
         logic [31:0] rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = {28'b0, 4'($urandom)};
         m = model(ro, ra, rb);
         run_check(ro, ra, rb, m[63:32], m[31:0], $sformatf("rnd%0d op%0d %h %h", i, ro, ra, rb));
      end

      // start while busy is ignored; start in the we cycle is accepted
      launch(2'b11, 32'd100, 32'd7);
      repeat (9) tick();
      op = 2'b01;
      rs_data = 32'd5;
      rt_data = 32'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      await_done("divu_ignore_start", 32'd2, 32'd14, 10);
      op = 2'b01;
      rs_data = 32'd3;
      rt_data = 32'd4;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("b2b busy_rise", {63'b0, busy}, 64'd1);
      await_done("b2b_multu", 32'd0, 32'd12, 0);
      tick();

      // cancel together with start in IDLE drops the start
      op = 2'b01;
      rs_data = 32'd9;
      rt_data = 32'd9;
      start = 1'b1;
      cancel = 1'b1;
      tick();
      start = 1'b0;
      cancel = 1'b0;
      chk("idle_cancel busy", {63'b0, busy}, 64'd0);

      // cancel mid-operation
      launch(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (9) tick();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      chk("cancel busy", {63'b0, busy}, 64'd0);
      we_seen = 0;
      for (int k = 0; k < 40; k++) begin
         if (hi_we || lo_we) we_seen++;
         tick();
      end
      chk("cancel no_we", 64'(we_seen), 64'd0);
      chk("cancel hilo_kept", {hi_out, lo_out}, {last_hi, last_lo});

      // asynchronous reset mid-operation
      launch(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (19) tick();
      rst = 1'b0;
      #1;
      chk("rst busy", {63'b0, busy}, 64'd0);
      chk("rst we", {62'b0, hi_we, lo_we}, 64'd0);
      chk("rst hilo", {hi_out, lo_out}, 64'd0);
      tick();
      rst = 1'b1;
      we_seen = 0;
      for (int k = 0; k < 40; k++) begin
         if (hi_we || lo_we) we_seen++;
         tick();
      end
      chk("rst no_we", 64'(we_seen), 64'd0);
      run_check(2'b11, 32'd7, 32'd2, 32'd1, 32'd3, "post_rst_divu");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
